i2c_cmd_sequencer: RTL and testbench

//  Upstream feeder for i2c_master. Buffers write/read commands {address, data, r_wb} in a FIFO.

---
 rtl/i2c_cmd_sequencer_pkg.sv | 26 ++
 rtl/i2c_cmd_sequencer_if.sv | 36 +++
 rtl/i2c_cmd_sequencer_fifo.sv | 55 +++++
 rtl/i2c_cmd_sequencer.sv | 144 ++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_cmd_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
//   Shared types for the I2C command sequencer: the buffered command record,
//   the sequencer FSM state encoding and the bus field widths.
// ----------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  // One queued command: target address, write payload and direction
  // (rw = 1 means the master reads from the slave).
  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] data;
    logic                  rw;
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    GAP
  } seq_state_t;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// i2c_cmd_sequencer_if
//   Bundles the host command handshake and the i2c_master-facing bus.
//   Host side : cmd_valid, cmd_ready, cmd_addr, cmd_data, cmd_rw
//   Master side: address, data_in, r_wb, enable, m_done, m_nack
//   modport master : the sequencer (accepts commands, drives the i2c_master)
//   modport slave  : the environment around it (host + i2c_master)
// ----------------------------------------------------------------------------
interface i2c_cmd_sequencer_if
  import i2c_pkg::*;
();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [I2C_ADDR_W-1:0] cmd_addr;
  logic [I2C_DATA_W-1:0] cmd_data;
  logic                  cmd_rw;

  logic [I2C_ADDR_W-1:0] address;
  logic [I2C_DATA_W-1:0] data_in;
  logic                  r_wb;
  logic                  enable;
  logic                  m_done;
  logic                  m_nack;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data, cmd_rw, m_done, m_nack,
    output cmd_ready, address, data_in, r_wb, enable
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data, cmd_rw, m_done, m_nack,
    input  cmd_ready, address, data_in, r_wb, enable
  );

endinterface

// File: rtl/i2c_cmd_sequencer_fifo.sv
// ----------------------------------------------------------------------------
// i2c_cmd_fifo
//   Synchronous FIFO of i2c_cmd_t with a combinational head (first-word
//   fall-through). Pointers carry one extra wrap bit so full and empty are
//   distinguishable and level spans 0..DEPTH.
//   Ports: clk, reset (sync, active-high), push/wr_data, pop, head,
//          full, empty, level.
//   Push while full and pop while empty are ignored.
// ----------------------------------------------------------------------------
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  i2c_cmd_t               wr_data,
  input  logic                   pop,
  output i2c_cmd_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  i2c_cmd_t         mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (PTR_W+1)'(DEPTH));
  assign head  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_cmd_sequencer
//   Upstream feeder for i2c_master. Queues host commands in a FIFO and
//   issues them one at a time, holding enable for the whole transaction,
//   with an idle gap between transactions and a timeout abort. Counts
//   completions, NACKs and timeouts (8-bit, wrapping).
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     bus (master modport)  host command handshake + i2c_master bus
//     level                 FIFO occupancy, 0..DEPTH
//     busy                  FSM not IDLE or FIFO non-empty
//     done_cnt/nack_cnt/tmo_cnt  status counters
//   Latency: command accepted in cycle N -> enable high in cycle N+3.
// ----------------------------------------------------------------------------
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  i2c_cmd_sequencer_if.master    bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic [7:0]             done_cnt,
  output logic [7:0]             nack_cnt,
  output logic [7:0]             tmo_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  seq_state_t       state;
  seq_state_t       state_next;
  i2c_cmd_t         cmd_in;
  i2c_cmd_t         head;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic             tmr_expired;
  logic             gap_last;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  assign cmd_in        = '{addr: bus.cmd_addr, data: bus.cmd_data, rw: bus.cmd_rw};
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;

  i2c_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (cmd_in),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  assign tmr_expired = (timer == TMR_W'(TIMEOUT - 1));
  assign gap_last    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (!empty) state_next = LOAD;
      LOAD: begin
        // Head is latched onto the bus and popped on the same edge.
        pop        = 1'b1;
        state_next = RUN;
      end
      // A done coinciding with expiry leaves RUN the same way; the counter
      // logic below credits it as a completion.
      RUN:  if (bus.m_done || tmr_expired) state_next = GAP;
      GAP:  if (gap_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE) || !empty;

  // --------------------------------------------------------------------------
  // Bus outputs, timers and status counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.enable  <= 1'b0;
      bus.address <= '0;
      bus.data_in <= '0;
      bus.r_wb    <= 1'b0;
      timer       <= '0;
      gap_cnt     <= '0;
      done_cnt    <= '0;
      nack_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      // Registered from the next state so enable is a clean flop output
      // that rises on entry to RUN and falls on exit.
      bus.enable <= (state_next == RUN);

      // Bus fields change only when a new command is loaded; they hold
      // their last value through GAP and IDLE.
      if (state == LOAD) begin
        bus.address <= head.addr;
        bus.data_in <= head.data;
        bus.r_wb    <= head.rw;
      end

      timer   <= (state == RUN) ? timer + TMR_W'(1)   : '0;
      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

      // m_done is only honoured in RUN; pulses in other states are dropped.
      if (state == RUN) begin
        if (bus.m_done) begin
          done_cnt <= done_cnt + 8'd1;
          if (bus.m_nack) nack_cnt <= nack_cnt + 8'd1;
        end else if (tmr_expired) begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_i2c_cmd_sequencer
//   Two instances: dut (TIMEOUT=1024) for normal traffic, fill and reset
//   behaviour; dut_t (TIMEOUT=16) for timeout behaviour. Inputs are driven
//   and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_i2c_cmd_sequencer;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_cmd_sequencer_if bus ();
  i2c_cmd_sequencer_if bus_t ();

  logic [2:0] level,    level_t;
  logic       busy,     busy_t;
  logic [7:0] done_cnt, nack_cnt, tmo_cnt;
  logic [7:0] done_t,   nack_t,   tmo_t;

  i2c_cmd_sequencer #(.DEPTH(4), .GAP_CYCLES(2), .TIMEOUT(1024)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .level    (level),
    .busy     (busy),
    .done_cnt (done_cnt),
    .nack_cnt (nack_cnt),
    .tmo_cnt  (tmo_cnt)
  );

  i2c_cmd_sequencer #(.DEPTH(4), .GAP_CYCLES(2), .TIMEOUT(16)) dut_t (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_t),
    .level    (level_t),
    .busy     (busy_t),
    .done_cnt (done_t),
    .nack_cnt (nack_t),
    .tmo_cnt  (tmo_t)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Present a command at the current falling edge and hold it until taken.
  // Returns with valid dropped, one falling edge after acceptance.
  task automatic push_cmd(input bit t, input logic [6:0] a, input logic [7:0] d,
                          input logic rw, output int waited);
    waited = 0;
    if (t) begin
      bus_t.cmd_valid = 1'b1; bus_t.cmd_addr = a; bus_t.cmd_data = d; bus_t.cmd_rw = rw;
    end else begin
      bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_rw = rw;
    end
    while (!(t ? bus_t.cmd_ready : bus.cmd_ready) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) bound_fail("push_ready");
    @(negedge clk);
    if (t) bus_t.cmd_valid = 1'b0;
    else   bus.cmd_valid   = 1'b0;
  endtask

  task automatic wait_en(input bit t, output int cyc);
    cyc = 0;
    while ((t ? bus_t.enable : bus.enable) !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) bound_fail("enable_rise");
  endtask

  // One-cycle m_done pulse; returns at the next falling edge.
  task automatic pulse_done(input bit t, input logic nack);
    if (t) begin bus_t.m_done = 1'b1; bus_t.m_nack = nack; end
    else   begin bus.m_done   = 1'b1; bus.m_nack   = nack; end
    @(negedge clk);
    if (t) begin bus_t.m_done = 1'b0; bus_t.m_nack = 1'b0; end
    else   begin bus.m_done   = 1'b0; bus.m_nack   = 1'b0; end
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       rw;
    int         delay;     // extra RUN cycles before m_done
    logic       nack;
    logic [7:0] exp_done;
    logic [7:0] exp_nack;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, cyc, run, cnt;
    bit   ok;
    logic [6:0] order [4];

    vecs[0] = '{addr: 7'h2D, data: 8'h67, rw: 1'b0, delay: 40, nack: 1'b0, exp_done: 8'd1, exp_nack: 8'd0};
    vecs[1] = '{addr: 7'h50, data: 8'hA5, rw: 1'b1, delay: 5,  nack: 1'b0, exp_done: 8'd2, exp_nack: 8'd0};
    vecs[2] = '{addr: 7'h3C, data: 8'hFF, rw: 1'b0, delay: 3,  nack: 1'b1, exp_done: 8'd3, exp_nack: 8'd1};
    vecs[3] = '{addr: 7'h00, data: 8'h00, rw: 1'b0, delay: 0,  nack: 1'b0, exp_done: 8'd4, exp_nack: 8'd1};
    vecs[4] = '{addr: 7'h7F, data: 8'h80, rw: 1'b1, delay: 7,  nack: 1'b1, exp_done: 8'd5, exp_nack: 8'd2};

    {bus.cmd_valid, bus.cmd_addr, bus.cmd_data, bus.cmd_rw, bus.m_done, bus.m_nack} = '0;
    {bus_t.cmd_valid, bus_t.cmd_addr, bus_t.cmd_data, bus_t.cmd_rw, bus_t.m_done, bus_t.m_nack} = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_enable",    bus.enable,    0);
    check("rst_level",     level,         0);
    check("rst_busy",      busy,          0);
    check("rst_counters",  {done_cnt, nack_cnt, tmo_cnt}, 0);
    check("rst_bus",       {bus.address, bus.data_in, bus.r_wb}, 0);

    // Table: single transactions, one at a time
    for (int i = 0; i < 5; i++) begin
      push_cmd(0, vecs[i].addr, vecs[i].data, vecs[i].rw, w);
      wait_en(0, cyc);
      check($sformatf("v%0d_latency", i), cyc, 2);
      check($sformatf("v%0d_address", i), bus.address, vecs[i].addr);
      if (!vecs[i].rw) check($sformatf("v%0d_data_in", i), bus.data_in, vecs[i].data);
      check($sformatf("v%0d_r_wb", i), bus.r_wb, vecs[i].rw);
      ok = 1'b1;
      repeat (vecs[i].delay) begin
        @(negedge clk);
        if (bus.enable !== 1'b1 || bus.address !== vecs[i].addr || bus.r_wb !== vecs[i].rw) ok = 1'b0;
      end
      check($sformatf("v%0d_run_stable", i), ok, 1);
      pulse_done(0, vecs[i].nack);
      check($sformatf("v%0d_enable_off", i), bus.enable, 0);
      check($sformatf("v%0d_done_cnt", i), done_cnt, vecs[i].exp_done);
      check($sformatf("v%0d_nack_cnt", i), nack_cnt, vecs[i].exp_nack);
      check($sformatf("v%0d_tmo_cnt", i), tmo_cnt, 0);
      check($sformatf("v%0d_addr_held", i), bus.address, vecs[i].addr);
      // GAP lasts exactly two cycles, then IDLE with an empty FIFO.
      check($sformatf("v%0d_gap1_busy", i), busy, 1);
      @(negedge clk);
      check($sformatf("v%0d_gap2", i), {busy, bus.enable}, 2'b10);
      @(negedge clk);
      check($sformatf("v%0d_idle", i), {busy, bus.enable}, 2'b00);
    end

    // Fill: one command in RUN, four queued, fifth must stall
    push_cmd(0, 7'h11, 8'h01, 1'b0, w);
    wait_en(0, cyc);
    for (int k = 0; k < 4; k++) begin
      push_cmd(0, 7'h12 + 7'(k), 8'h10 + 8'(k), 1'b0, w);
      check($sformatf("fill_accept%0d", k), w, 0);
    end
    check("fill_level",     level,         4);
    check("fill_ready_low", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 7'h16; bus.cmd_data = 8'h14; bus.cmd_rw = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.cmd_ready !== 1'b0 || level !== 3'd4) ok = 1'b0;
    end
    check("fill_stalled", ok, 1);
    pulse_done(0, 1'b0);                     // first command completes
    cnt = 0;
    while (bus.cmd_ready !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("fill_ready_after_pop", cnt, 4);   // GAP2, IDLE, LOAD, then RUN
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("fill_level_refill", level, 4);
    check("fill_b_address", bus.address, 7'h12);
    repeat (2) @(negedge clk);
    pulse_done(0, 1'b1);                     // NACK on the second command
    check("nack_nack_cnt", nack_cnt, 8'd3);
    check("nack_done_cnt", done_cnt, 8'd7);
    order = '{7'h13, 7'h14, 7'h15, 7'h16};
    for (int k = 0; k < 4; k++) begin
      wait_en(0, cyc);
      check($sformatf("order%0d_address", k), bus.address, order[k]);
      pulse_done(0, 1'b0);
    end
    check("fill_done_cnt", done_cnt, 8'd11);
    repeat (3) @(negedge clk);
    check("fill_drained", {busy, level}, 4'b0000);

    // Timeout on the TIMEOUT=16 instance
    push_cmd(1, 7'h22, 8'h33, 1'b0, w);
    wait_en(1, cyc);
    run = 1;
    while (bus_t.enable === 1'b1 && run < 40) begin
      @(negedge clk);
      if (bus_t.enable === 1'b1) run++;
    end
    check("tmo_run_len",  run,    16);
    check("tmo_tmo_cnt",  tmo_t,  8'd1);
    check("tmo_done_cnt", done_t, 8'd0);
    pulse_done(1, 1'b1);                     // late m_done during GAP
    check("tmo_late_done", {done_t, nack_t, tmo_t}, {8'd0, 8'd0, 8'd1});
    @(negedge clk);
    check("tmo_idle", {busy_t, bus_t.enable}, 2'b00);

    // Read command, m_done on the same cycle the timer expires
    push_cmd(1, 7'h50, 8'h00, 1'b1, w);
    wait_en(1, cyc);
    check("rd_r_wb", bus_t.r_wb, 1);
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus_t.enable !== 1'b1 || bus_t.r_wb !== 1'b1) ok = 1'b0;
    end
    check("rd_hold", ok, 1);
    pulse_done(1, 1'b0);
    check("coincide_counts", {done_t, nack_t, tmo_t}, {8'd1, 8'd0, 8'd1});
    check("coincide_enable", bus_t.enable, 0);

    // Reset mid-RUN with two commands still queued
    push_cmd(0, 7'h21, 8'h01, 1'b0, w);
    push_cmd(0, 7'h22, 8'h02, 1'b0, w);
    push_cmd(0, 7'h23, 8'h03, 1'b0, w);
    wait_en(0, cyc);
    check("pre_rst_level", level, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_enable",   bus.enable, 0);
    check("mid_rst_level",    level,      0);
    check("mid_rst_counters", {done_cnt, nack_cnt, tmo_cnt}, 0);
    check("mid_rst_ready",    bus.cmd_ready, 1);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.enable !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("mid_rst_quiet", ok, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
